fp16_div_seq: RTL and testbench

FP16_DIV_SEQ -- requirements
Module: fp16_div_seq

---
 rtl/fp16_pkg.sv | 16 +
 rtl/fp16_round_pack.sv | 39 +++
 rtl/fp16_div_seq.sv | 132 +++++++++++++
 tb/tb_fp16_div_seq.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fp16_pkg.sv
// Shared binary16 constants and the divider FSM state type.
package fp16_pkg;

   localparam int FP16_BIAS = 15;
   localparam int EXP_W     = 5;
   localparam int FRAC_W    = 10;
   localparam int Q_BITS    = 12;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DIV   = 2'd1,
      ROUND = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/fp16_round_pack.sv
// Combinational RNE rounding, exponent adjust, clamp and binary16 packing.
// sig is 1 integer bit, FRAC_W fraction bits and one guard bit, MSB first.
module fp16_round_pack
   import fp16_pkg::*;
(
   input  logic                    sign,
   input  logic signed [7:0]       exp_pre,
   input  logic [Q_BITS-1:0]       sig,
   input  logic                    sticky,
   input  logic                    div_by_zero,
   output logic [15:0]             result,
   output logic                    overflow,
   output logic                    underflow
);

   logic                round_up;
   logic [Q_BITS-1:0]   sig_rnd;
   logic                carry;
   logic [FRAC_W-1:0]   frac;
   logic signed [7:0]   exp_fin;

   always_comb begin
      round_up  = sig[0] & (sticky | sig[1]);
      sig_rnd   = {1'b0, sig[Q_BITS-1:1]} + {{(Q_BITS-1){1'b0}}, round_up};
      // A carry means the significand rounded up to 2.0: renormalise by one.
      carry     = sig_rnd[Q_BITS-1];
      frac      = carry ? sig_rnd[FRAC_W:1] : sig_rnd[FRAC_W-1:0];
      exp_fin   = exp_pre + $signed({7'b0, carry});
      overflow  = !div_by_zero && (exp_fin >= 8'sd31);
      underflow = !div_by_zero && !overflow && (exp_fin <= 8'sd0);
      result    = {sign, exp_fin[EXP_W-1:0], frac};
      if (div_by_zero || overflow) begin
         result = {sign, 5'd30, 10'h3FF};
      end else if (underflow) begin
         result = {sign, 15'd0};
      end
   end

endmodule

// File: rtl/fp16_div_seq.sv
// Sequential binary16 divider: restoring division, one quotient bit per cycle.
// Define FP16_DIV_STATUS_EN to add the status [2:0] = {div_by_zero, overflow, underflow} port.
module fp16_div_seq
   import fp16_pkg::*;
#(
   parameter int WIDTH = 16
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quotient
`ifdef FP16_DIV_STATUS_EN
   ,
   output logic [2:0]       status
`endif
);

   // Handshake: a transfer happens on a rising edge where valid && ready are
   // both high; valid and its payload stay stable until that edge.

   state_t              state;
   logic [3:0]          cnt;
   logic [EXP_W-1:0]    ea_r;
   logic [EXP_W-1:0]    eb_r;
   logic                s_r;
   logic                lt_r;
   logic                dz_r;
   logic [10:0]         mb_r;
   logic [11:0]         rem;
   logic [Q_BITS-1:0]   q;

   logic [10:0]         ma_in;
   logic [10:0]         mb_in;
   logic                rem_ge;
   logic [11:0]         rem_step;
   logic signed [7:0]   exp_pre;
   logic [15:0]         rp_result;
   logic                rp_overflow;
   logic                rp_underflow;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   assign ma_in    = {1'b1, a[FRAC_W-1:0]};
   assign mb_in    = {1'b1, b[FRAC_W-1:0]};
   assign rem_ge   = (rem >= {1'b0, mb_r});
   assign rem_step = rem_ge ? (rem - {1'b0, mb_r}) : rem;
   assign exp_pre  = $signed({3'b0, ea_r} - {3'b0, eb_r} + 8'(FP16_BIAS) - {7'b0, lt_r});

   fp16_round_pack u_round_pack (
      .sign        (s_r),
      .exp_pre     (exp_pre),
      .sig         (q),
      .sticky      (|rem),
      .div_by_zero (dz_r),
      .result      (rp_result),
      .overflow    (rp_overflow),
      .underflow   (rp_underflow)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= 4'd0;
         ea_r     <= '0;
         eb_r     <= '0;
         s_r      <= 1'b0;
         lt_r     <= 1'b0;
         dz_r     <= 1'b0;
         mb_r     <= '0;
         rem      <= '0;
         q        <= '0;
         quotient <= '0;
`ifdef FP16_DIV_STATUS_EN
         status   <= 3'b000;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  ea_r  <= a[14:10];
                  eb_r  <= b[14:10];
                  s_r   <= a[WIDTH-1] ^ b[WIDTH-1];
                  dz_r  <= (b[14:10] == 5'd0);
                  mb_r  <= mb_in;
                  // Pre-shift a smaller dividend so the first quotient bit is always 1.
                  lt_r  <= (ma_in < mb_in);
                  rem   <= (ma_in < mb_in) ? {ma_in, 1'b0} : {1'b0, ma_in};
                  q     <= '0;
                  cnt   <= 4'd0;
                  state <= DIV;
               end
            end
            DIV: begin
               q   <= {q[Q_BITS-2:0], rem_ge};
               rem <= {rem_step[10:0], 1'b0};
               if (cnt == 4'(Q_BITS - 1)) begin
                  cnt   <= 4'd0;
                  state <= ROUND;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            ROUND: begin
               quotient <= rp_result;
`ifdef FP16_DIV_STATUS_EN
               status   <= {dz_r, rp_overflow, rp_underflow};
`endif
               state    <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifndef FP16_DIV_STATUS_EN
   logic unused_flags;
   assign unused_flags = rp_overflow ^ rp_underflow;
`endif

endmodule

// File: tb/tb_fp16_div_seq.sv
// Directed bench for fp16_div_seq with an arithmetic reference model and
// a per-cycle handshake/latency scoreboard.
module tb_fp16_div_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] quotient;
`ifdef FP16_DIV_STATUS_EN
   logic [2:0]  status;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   logic [15:0] exp_q[$];
   logic [2:0]  exp_st_q[$];
   bit          mon_en = 1'b0;
   bit          busy   = 1'b0;
   int          age    = 0;
   logic [18:0] mon_m;

   localparam int NV = 11;
   logic [15:0] va [NV];
   logic [15:0] vb [NV];
   logic [15:0] vq [NV];
   logic [2:0]  vs [NV];

   fp16_div_seq #(.WIDTH(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .quotient  (quotient)
`ifdef FP16_DIV_STATUS_EN
      ,
      .status    (status)
`endif
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: actual no finish, required finish before 1ms");
      $fatal(1, "watchdog expired");
   end

   // ---------------- reference model ----------------
   function automatic logic [18:0] model_div(input logic [15:0] x, input logic [15:0] y);
      int ea, eb, ma, mb, e, num, qq, rr, sig;
      logic sgn;
      logic [15:0] r;
      logic [2:0] st;
      sgn = x[15] ^ y[15];
      ea  = int'(x[14:10]);
      eb  = int'(y[14:10]);
      ma  = 1024 + int'(x[9:0]);
      mb  = 1024 + int'(y[9:0]);
      e   = ea - eb + 15;
      num = ma;
      if (ma < mb) begin
         num = 2 * ma;
         e   = e - 1;
      end
      qq  = (num * 2048) / mb;
      rr  = (num * 2048) % mb;
      sig = qq / 2;
      if ((qq % 2) == 1 && (rr != 0 || (sig % 2) == 1)) sig = sig + 1;
      if (sig == 2048) begin
         sig = 1024;
         e   = e + 1;
      end
      if (eb == 0) begin
         r  = {sgn, 5'd30, 10'h3FF};
         st = 3'b100;
      end else if (e >= 31) begin
         r  = {sgn, 5'd30, 10'h3FF};
         st = 3'b010;
      end else if (e <= 0) begin
         r  = {sgn, 15'd0};
         st = 3'b001;
      end else begin
         r  = {sgn, 5'(e), 10'(sig % 1024)};
         st = 3'b000;
      end
      return {st, r};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_tests++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h at %0t", name, act, expv, $time);
      end
   endtask

   // ---------------- scoreboard / per-cycle compare ----------------
   always @(negedge clk) begin
      if (mon_en) begin
         check("in_ready", {31'b0, in_ready}, {31'b0, !busy});
         check("out_valid", {31'b0, out_valid}, {31'b0, busy && age >= 14});
         if (busy && age >= 14 && exp_q.size() > 0) begin
            check("quotient", {16'b0, quotient}, {16'b0, exp_q[0]});
`ifdef FP16_DIV_STATUS_EN
            check("status", {29'b0, status}, {29'b0, exp_st_q[0]});
`endif
         end
         if (rst) begin
            busy = 1'b0;
            age  = 0;
            exp_q.delete();
            exp_st_q.delete();
         end else if (busy) begin
            if (age >= 14 && out_ready) begin
               busy = 1'b0;
               void'(exp_q.pop_front());
               void'(exp_st_q.pop_front());
            end else begin
               age++;
            end
         end else if (in_valid) begin
            mon_m = model_div(a, b);
            exp_q.push_back(mon_m[15:0]);
            exp_st_q.push_back(mon_m[18:16]);
            busy = 1'b1;
            age  = 1;
         end
      end
   end

   // ---------------- driver ----------------
   task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic [15:0] eq,
                         input logic [2:0] es, input int hold, input bit pulse);
      int n;
      @(posedge clk); #1;
      a = ta;
      b = tb_v;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      n = 1;
      while (!out_valid && n < 40) begin
         @(posedge clk); #1;
         n++;
         if (pulse && n == 3) begin
            a = 16'h5555;
            b = 16'h1234;
            in_valid = 1'b1;
         end
         if (pulse && n == 5) in_valid = 1'b0;
      end
      check("latency", n, 14);
      check("result", {16'b0, quotient}, {16'b0, eq});
`ifdef FP16_DIV_STATUS_EN
      check("result status", {29'b0, status}, {29'b0, es});
`else
      if (es == 3'b111) $display("unexpected status code");
`endif
      repeat (hold) begin
         @(posedge clk); #1;
         check("hold quotient", {16'b0, quotient}, {16'b0, eq});
         check("hold in_ready", {31'b0, in_ready}, 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("post handshake out_valid", {31'b0, out_valid}, 32'd0);
      check("post handshake in_ready", {31'b0, in_ready}, 32'd1);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [18:0] m;
      va = '{16'h3C00, 16'h4600, 16'hC600, 16'h3C00, 16'h7BFF, 16'h0400,
             16'h3C00, 16'h4500, 16'h8400, 16'hC000, 16'hBC00};
      vb = '{16'h3C00, 16'h4000, 16'h4000, 16'h4200, 16'h2C00, 16'h4000,
             16'h0000, 16'h4200, 16'h4000, 16'h0000, 16'hC200};
      vq = '{16'h3C00, 16'h4200, 16'hC200, 16'h3555, 16'h7BFF, 16'h0000,
             16'h7BFF, 16'h3EAB, 16'h8000, 16'hFBFF, 16'h3555};
      vs = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b010, 3'b001,
             3'b100, 3'b000, 3'b001, 3'b100, 3'b000};

      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      a = '0;
      b = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      mon_en = 1'b1;
      @(negedge clk);
      check("reset quotient", {16'b0, quotient}, 32'h0);
      check("reset in_ready", {31'b0, in_ready}, 32'd1);
      check("reset out_valid", {31'b0, out_valid}, 32'd0);
`ifdef FP16_DIV_STATUS_EN
      check("reset status", {29'b0, status}, 32'd0);
`endif

      for (int i = 0; i < NV; i++) begin
         m = model_div(va[i], vb[i]);
         check("model quotient", {16'b0, m[15:0]}, {16'b0, vq[i]});
         check("model status", {29'b0, m[18:16]}, {29'b0, vs[i]});
      end

      for (int i = 0; i < NV; i++) begin
         run_op(va[i], vb[i], vq[i], vs[i], (i == 2) ? 5 : 0, (i == 3));
      end

      // Abort mid-division: nothing may be presented afterwards.
      @(posedge clk); #1;
      a = 16'h3C00;
      b = 16'h3C00;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort in_ready", {31'b0, in_ready}, 32'd1);
      check("abort out_valid", {31'b0, out_valid}, 32'd0);
      repeat (20) begin
         @(posedge clk); #1;
         check("abort silent", {31'b0, out_valid}, 32'd0);
      end

      run_op(16'h4600, 16'h4000, 16'h4200, 3'b000, 1, 1'b0);

      repeat (3) @(posedge clk);
      #1;
      check("scoreboard empty", exp_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
